tcu_fedp_chain: RTL and testbench

TCU_FEDP_CHAIN -- requirements
Module: tcu_fedp_chain

---
 rtl/tcu_fedp_chain.sv | 130 +++++++++++++
 tb/tb_tcu_fedp_chain.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcu_fedp_chain.sv
// Chunk sequencer in front of the TCU fused dot-product unit: issues one N-wide chunk at a time
// and feeds each FEDP result back as the next chunk's c_val.
//   state | meaning
//   IDLE  | waiting for the first chunk of a dot product
//   ISSUE | one-cycle FEDP issue of the latched chunk
//   WAIT  | counting down the FEDP latency, captures d_val at zero
//   CHAIN | waiting for the next chunk of the current dot product
//   RESP  | holding the final result until accepted
module tcu_fedp_chain #(
  parameter int N              = 2,
  parameter int LATENCY        = 4,
  parameter int TAGW           = 8,
  parameter int CNTW           = 8,
  parameter int TCU_MAX_INPUTS = N
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_first,
  input  logic                      req_last,
  input  logic [TAGW-1:0]           req_tag,
  input  logic [3:0]                req_fmt_s,
  input  logic [TCU_MAX_INPUTS-1:0] req_vld_mask,
  input  logic [N*32-1:0]           req_a_row,
  input  logic [N*32-1:0]           req_b_col,
  input  logic [31:0]               req_c_val,
  output logic                      fedp_enable,
  output logic [TCU_MAX_INPUTS-1:0] fedp_vld_mask,
  output logic [3:0]                fedp_fmt_s,
  output logic [N*32-1:0]           fedp_a_row,
  output logic [N*32-1:0]           fedp_b_col,
  output logic [31:0]               fedp_c_val,
  input  logic [31:0]               fedp_d_val,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_data,
  output logic [TAGW-1:0]           rsp_tag,
  output logic [CNTW-1:0]           rsp_chunks,
  output logic                      err_restart
);

  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHAIN, S_RESP} state_t;

  state_t                    r_state, w_next;
  logic [31:0]               r_acc;
  logic [TAGW-1:0]           r_tag;
  logic [CNTW-1:0]           r_cnt;
  logic [WW-1:0]             r_wcnt;
  logic                      r_last;
  logic [3:0]                r_fmt;
  logic [TCU_MAX_INPUTS-1:0] r_mask;
  logic [N*32-1:0]           r_a;
  logic [N*32-1:0]           r_b;
  logic                      w_fire;
  logic                      w_start;

  assign req_ready   = !reset && (r_state == S_IDLE || r_state == S_CHAIN);
  assign w_fire      = req_valid && req_ready;
  // A first-flagged chunk inside a chain abandons the partial sum and starts over.
  assign w_start     = w_fire && (r_state == S_IDLE || req_first);
  assign err_restart = w_fire && (r_state == S_CHAIN) && req_first;

  assign fedp_enable   = !reset;
  assign fedp_vld_mask = (!reset && r_state == S_ISSUE) ? r_mask : '0;
  assign fedp_fmt_s    = r_fmt;
  assign fedp_a_row    = r_a;
  assign fedp_b_col    = r_b;
  assign fedp_c_val    = r_acc;

  assign rsp_valid  = !reset && (r_state == S_RESP);
  assign rsp_data   = r_acc;
  assign rsp_tag    = r_tag;
  assign rsp_chunks = r_cnt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_CHAIN: begin
        if (w_fire) begin
          if (req_vld_mask == '0) w_next = req_last ? S_RESP : S_CHAIN;
          else                    w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_wcnt == '0) w_next = r_last ? S_RESP : S_CHAIN;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_tag   <= '0;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_last  <= 1'b0;
      r_fmt   <= '0;
      r_mask  <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_next;
      if (w_fire) begin
        r_a    <= req_a_row;
        r_b    <= req_b_col;
        r_fmt  <= req_fmt_s;
        r_mask <= req_vld_mask;
        r_last <= req_last;
        if (w_start) begin
          r_acc <= req_c_val;
          r_tag <= req_tag;
          r_cnt <= CNTW'(1);
        end else if (r_cnt != '1) begin
          r_cnt <= r_cnt + CNTW'(1);
        end
      end
      if (r_state == S_ISSUE) r_wcnt <= WW'(LATENCY - 1);
      if (r_state == S_WAIT) begin
        if (r_wcnt == '0) r_acc  <= fedp_d_val;
        else              r_wcnt <= r_wcnt - WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tcu_fedp_chain.sv
// Directed bench for tcu_fedp_chain; a behavioural FEDP returns queued results exactly LATENCY
// cycles after each issue and garbage at every other time.
module tb_tcu_fedp_chain;
  localparam int N    = 2;
  localparam int LAT  = 4;
  localparam int TAGW = 8;
  localparam int CNTW = 8;
  localparam int MI   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid, req_ready, req_first, req_last;
  logic [TAGW-1:0] req_tag;
  logic [3:0]      req_fmt_s;
  logic [MI-1:0]   req_vld_mask;
  logic [N*32-1:0] req_a_row, req_b_col;
  logic [31:0]     req_c_val;
  logic            fedp_enable;
  logic [MI-1:0]   fedp_vld_mask;
  logic [3:0]      fedp_fmt_s;
  logic [N*32-1:0] fedp_a_row, fedp_b_col;
  logic [31:0]     fedp_c_val, fedp_d_val;
  logic            rsp_valid, rsp_ready;
  logic [31:0]     rsp_data;
  logic [TAGW-1:0] rsp_tag;
  logic [CNTW-1:0] rsp_chunks;
  logic            err_restart;

  int vectors = 0;
  int miscompares = 0;
  int issue_cnt = 0;
  logic [31:0] res_q[$];
  logic [31:0] cval_q[$];
  logic [32:0] pipe[LAT+1];

  tcu_fedp_chain #(.N(N), .LATENCY(LAT), .TAGW(TAGW), .CNTW(CNTW), .TCU_MAX_INPUTS(MI)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_first(req_first), .req_last(req_last),
    .req_tag(req_tag), .req_fmt_s(req_fmt_s), .req_vld_mask(req_vld_mask),
    .req_a_row(req_a_row), .req_b_col(req_b_col), .req_c_val(req_c_val),
    .fedp_enable(fedp_enable), .fedp_vld_mask(fedp_vld_mask), .fedp_fmt_s(fedp_fmt_s),
    .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col), .fedp_c_val(fedp_c_val),
    .fedp_d_val(fedp_d_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_chunks(rsp_chunks), .err_restart(err_restart)
  );

  always #5 clk = ~clk;

  // Stage LAT holds a result from the negedge of cycle issue+LAT, across the capture edge.
  always @(negedge clk) begin
    for (int j = LAT; j > 0; j--) pipe[j] = pipe[j-1];
    if (!reset && fedp_vld_mask != '0) begin
      issue_cnt++;
      cval_q.push_back(fedp_c_val);
      if (res_q.size() > 0) pipe[0] = {1'b1, res_q.pop_front()};
      else                  pipe[0] = {1'b1, 32'hBAADF00D};
    end else begin
      pipe[0] = {1'b0, 32'hDEADBEEF};
    end
  end
  assign fedp_d_val = pipe[LAT][31:0];

  task automatic send(input logic first, input logic last, input logic [TAGW-1:0] tag,
                      input logic [MI-1:0] mask, input logic [N*32-1:0] a,
                      input logic [N*32-1:0] b, input logic [31:0] c, output logic err);
    logic ok;
    ok = 1'b0;
    err = 1'b0;
    req_valid = 1'b1; req_first = first; req_last = last; req_tag = tag;
    req_vld_mask = mask; req_a_row = a; req_b_col = b; req_c_val = c; req_fmt_s = 4'h3;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    err = err_restart;
    if (ok) @(posedge clk);
    #1 req_valid = 1'b0; req_first = 1'b0; req_last = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout req_ready never seen within 200 cycles");
    end
  endtask

  task automatic wait_rsp();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout rsp_valid never seen within 200 cycles");
    end
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_first = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, fedp_enable, err_restart} !== 4'b0000 || fedp_vld_mask !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b rv=%b en=%b err=%b msk=%b exp all 0",
               req_ready, rsp_valid, fedp_enable, err_restart, fedp_vld_mask);
    end
    req_valid = 1'b0; req_first = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req_ready, fedp_enable, rsp_valid} !== 3'b110) begin
      miscompares++;
      $display("FAIL post_reset_ctrl got rdy=%b en=%b rv=%b exp 1 1 0", req_ready, fedp_enable, rsp_valid);
    end
    vectors++;
    if (rsp_data !== 32'h0 || rsp_tag !== 8'h0 || rsp_chunks !== 8'h0) begin
      miscompares++;
      $display("FAIL post_reset_regs got data=%h tag=%h cnt=%0d exp 0 0 0", rsp_data, rsp_tag, rsp_chunks);
    end
  endtask

  task automatic test_single();
    logic err;
    logic [N*32-1:0] a, b;
    a = {32'h40000000, 32'h3F800000};
    b = {32'h40800000, 32'h40400000};
    issue_cnt = 0; cval_q.delete();
    res_q = {32'h41380000};
    send(1'b1, 1'b1, 8'hA5, 2'b11, a, b, 32'h3F000000, err);
    for (int k = 1; k <= 7; k++) begin
      vectors++;
      if ({fedp_vld_mask != '0, rsp_valid} !== {k == 1, k >= 6}) begin
        miscompares++;
        $display("FAIL single_timing cycle %0d got issue=%b rv=%b exp %b %b",
                 k, fedp_vld_mask != '0, rsp_valid, k == 1, k >= 6);
      end
      if (k == 1) begin
        vectors++;
        if (fedp_c_val !== 32'h3F000000 || fedp_a_row !== a || fedp_b_col !== b ||
            fedp_fmt_s !== 4'h3 || fedp_vld_mask !== 2'b11) begin
          miscompares++;
          $display("FAIL single_issue got c=%h a=%h b=%h fmt=%h msk=%b", fedp_c_val, fedp_a_row,
                   fedp_b_col, fedp_fmt_s, fedp_vld_mask);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (rsp_data !== 32'h41380000 || rsp_tag !== 8'hA5 || rsp_chunks !== 8'd1 || issue_cnt !== 1) begin
      miscompares++;
      $display("FAIL single_rsp got data=%h tag=%h cnt=%0d issues=%0d exp 41380000 a5 1 1",
               rsp_data, rsp_tag, rsp_chunks, issue_cnt);
    end
    accept_rsp();
  endtask

  task automatic test_chain3();
    logic err;
    issue_cnt = 0; cval_q.delete();
    res_q = {32'h3F800000, 32'h40000000, 32'h40400000};
    send(1'b1, 1'b0, 8'h31, 2'b11, '1, '1, 32'h0, err);
    send(1'b0, 1'b0, 8'hEE, 2'b11, '1, '1, 32'h12345678, err);
    send(1'b0, 1'b1, 8'hEE, 2'b01, '1, '1, 32'h12345678, err);
    wait_rsp();
    vectors++;
    if (issue_cnt !== 3 || cval_q[0] !== 32'h0 || cval_q[1] !== 32'h3F800000 || cval_q[2] !== 32'h40000000) begin
      miscompares++;
      $display("FAIL chain3_cvals got issues=%0d c0=%h c1=%h c2=%h exp 3 0 3f800000 40000000",
               issue_cnt, cval_q[0], cval_q[1], cval_q[2]);
    end
    vectors++;
    if (rsp_data !== 32'h40400000 || rsp_tag !== 8'h31 || rsp_chunks !== 8'd3) begin
      miscompares++;
      $display("FAIL chain3_rsp got data=%h tag=%h cnt=%0d exp 40400000 31 3", rsp_data, rsp_tag, rsp_chunks);
    end
    accept_rsp();
  endtask

  task automatic test_skip();
    logic err;
    issue_cnt = 0; cval_q.delete();
    res_q = {32'h3F800000, 32'h40000000};
    send(1'b1, 1'b0, 8'h42, 2'b11, '1, '1, 32'h0, err);
    send(1'b0, 1'b0, 8'h00, 2'b00, '1, '1, 32'h0, err);
    send(1'b0, 1'b1, 8'h00, 2'b10, '1, '1, 32'h0, err);
    wait_rsp();
    vectors++;
    if (issue_cnt !== 2 || cval_q[1] !== 32'h3F800000) begin
      miscompares++;
      $display("FAIL skip_issues got issues=%0d c1=%h exp 2 3f800000", issue_cnt, cval_q[1]);
    end
    vectors++;
    if (rsp_data !== 32'h40000000 || rsp_chunks !== 8'd3) begin
      miscompares++;
      $display("FAIL skip_rsp got data=%h cnt=%0d exp 40000000 3", rsp_data, rsp_chunks);
    end
    accept_rsp();
  endtask

  task automatic test_restart();
    logic err_a, err_b;
    issue_cnt = 0; cval_q.delete();
    res_q = {32'h40A00000, 32'h40000000};
    send(1'b1, 1'b0, 8'h11, 2'b11, '1, '1, 32'h0, err_a);
    send(1'b1, 1'b1, 8'h22, 2'b11, '1, '1, 32'h3F800000, err_b);
    vectors++;
    if ({err_a, err_b, err_restart} !== 3'b010) begin
      miscompares++;
      $display("FAIL restart_pulse got first=%b restart=%b after=%b exp 0 1 0", err_a, err_b, err_restart);
    end
    wait_rsp();
    vectors++;
    if (rsp_data !== 32'h40000000 || rsp_tag !== 8'h22 || rsp_chunks !== 8'd1 || cval_q[1] !== 32'h3F800000) begin
      miscompares++;
      $display("FAIL restart_rsp got data=%h tag=%h cnt=%0d c1=%h exp 40000000 22 1 3f800000",
               rsp_data, rsp_tag, rsp_chunks, cval_q[1]);
    end
    accept_rsp();
  endtask

  task automatic test_backpressure();
    logic err;
    issue_cnt = 0; cval_q.delete();
    res_q = {32'h40400000};
    send(1'b1, 1'b1, 8'h5A, 2'b01, '1, '1, 32'h0, err);
    wait_rsp();
    req_valid = 1'b1; req_first = 1'b1; req_tag = 8'h99; req_c_val = 32'h7F000000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== 32'h40400000 || rsp_tag !== 8'h5A) begin
        miscompares++;
        $display("FAIL hold_rsp cycle %0d got rv=%b rdy=%b data=%h tag=%h exp 1 0 40400000 5a",
                 k, rsp_valid, req_ready, rsp_data, rsp_tag);
      end
    end
    req_valid = 1'b0; req_first = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL accept_cycle got rv=%b rdy=%b exp 1 0", rsp_valid, req_ready);
    end
    @(posedge clk); #1 rsp_ready = 1'b0;
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01 || issue_cnt !== 1) begin
      miscompares++;
      $display("FAIL back_to_idle got rv=%b rdy=%b issues=%0d exp 0 1 1", rsp_valid, req_ready, issue_cnt);
    end
  endtask

  task automatic test_reset_in_wait();
    logic err;
    int seen;
    issue_cnt = 0; cval_q.delete();
    res_q = {32'h11111111};
    send(1'b1, 1'b1, 8'h33, 2'b11, '1, '1, 32'h0, err);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    vectors++;
    if (seen !== 0 || rsp_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_abandon got rv_cycles=%0d data=%h exp 0 0", seen, rsp_data);
    end
    issue_cnt = 0; cval_q.delete();
    res_q = {32'h40400000};
    send(1'b1, 1'b1, 8'h44, 2'b11, '1, '1, 32'h3F800000, err);
    wait_rsp();
    vectors++;
    if (rsp_data !== 32'h40400000 || rsp_tag !== 8'h44 || rsp_chunks !== 8'd1 || cval_q[0] !== 32'h3F800000) begin
      miscompares++;
      $display("FAIL after_reset_rsp got data=%h tag=%h cnt=%0d c0=%h exp 40400000 44 1 3f800000",
               rsp_data, rsp_tag, rsp_chunks, cval_q[0]);
    end
    accept_rsp();
  endtask

  task automatic test_saturate();
    logic err;
    issue_cnt = 0; cval_q.delete();
    res_q.delete();
    send(1'b1, 1'b0, 8'h77, 2'b00, '0, '0, 32'h3F800000, err);
    for (int i = 1; i < 300; i++) send(1'b0, i == 299, 8'h00, 2'b00, '0, '0, 32'h0, err);
    wait_rsp();
    vectors++;
    if (rsp_chunks !== 8'hFF || rsp_data !== 32'h3F800000 || issue_cnt !== 0) begin
      miscompares++;
      $display("FAIL saturate got cnt=%0d data=%h issues=%0d exp 255 3f800000 0",
               rsp_chunks, rsp_data, issue_cnt);
    end
    accept_rsp();
  endtask

  initial begin
    for (int j = 0; j <= LAT; j++) pipe[j] = {1'b0, 32'hDEADBEEF};
    reset = 1'b1; rsp_ready = 1'b0; req_valid = 1'b0; req_first = 1'b0; req_last = 1'b0;
    req_tag = '0; req_fmt_s = '0; req_vld_mask = '0; req_a_row = '0; req_b_col = '0; req_c_val = '0;
    test_reset();
    test_single();
    test_chain3();
    test_skip();
    test_restart();
    test_backpressure();
    test_reset_in_wait();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
